bcd_down_counter: RTL and testbench
===================================

BCD_DOWN_COUNTER -- requirements
Module: bcd_down_counter

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, giving the number of BCD digits (legal range 1..8).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port load, input, 1 bit: load request for load_val.
REQ-005 The block SHALL have port load_val, input, 4*NUM_DIGITS bits: packed BCD start value, digit 0 in bits [3:0].
REQ-006 The block SHALL have port enable, input, 1 bit: count-down request.
REQ-007 The block SHALL have port Q, output, 4*NUM_DIGITS bits: current packed BCD count, registered.
REQ-008 The block SHALL have port zero, output, 1 bit: combinational, high when Q equals all-zero digits.
REQ-009 The block SHALL have port done, output, 1 bit: registered one-cycle pulse on reaching zero by counting.
REQ-010 The block SHALL have port load_err, output, 1 bit: registered one-cycle pulse on rejected load.

Function
REQ-011 Per-edge priority SHALL be reset, then load, then enable, then hold.
REQ-012 On load, if every digit of load_val is 0..9, Q SHALL take load_val at that edge (latency 1 cycle); enable in the same cycle SHALL be ignored.
REQ-013 On load with any digit of load_val in 10..15, Q SHALL hold, load_err SHALL be 1 for exactly the next cycle, and enable in that cycle SHALL be ignored.
REQ-014 On enable without load and with Q nonzero, Q SHALL decrement by one in decimal: digit 0 decrements, any digit at 0 becomes 9 and borrows into the next digit, and borrow propagates through all digits within the same cycle.
REQ-015 On enable without load and with Q zero, Q SHALL follow REQ-022/REQ-023.
REQ-016 done SHALL be 1 for exactly the cycle after an edge at which Q went from nonzero to zero by decrement, and 0 otherwise.
REQ-017 A load of value zero SHALL NOT assert done.
REQ-018 Each decrement SHALL be arithmetically correct.
REQ-019 Q SHALL never hold a non-BCD digit.
REQ-020 Digit width SHALL be exactly 4 bits.
REQ-021 No carry or borrow SHALL leave the most significant digit.

Configuration
REQ-022 Macro BCD_DOWN_COUNTER_AUTO_RELOAD_EN SHALL be defined for auto-reload builds. In those builds, the block SHALL keep a reload register that captures every accepted load_val and resets to zero. An enable with Q zero SHALL then load Q from the reload register, and done SHALL NOT be asserted for that reload.
REQ-023 When BCD_DOWN_COUNTER_AUTO_RELOAD_EN is undefined, there SHALL be no reload register, and an enable with Q zero SHALL leave Q at zero with done low.

Reset
REQ-024 When reset is 1 at a rising clk edge, Q SHALL become zero, and done and load_err SHALL become 0.
REQ-025 With auto-reload compiled in, reset SHALL also clear the reload register to zero.
REQ-026 Reset asserted mid-count or concurrently with load or enable SHALL win; load and enable SHALL be ignored in that cycle.
REQ-027 With reset held, zero SHALL read 1.

Verification
REQ-028 Scenario, load then count to zero: NUM_DIGITS=4; load 0x0003, then enable for 3 cycles -> Q is 0002, 0001, 0000; done is 1 exactly in the cycle after Q became 0000; zero is 1 from then on.
REQ-029 Scenario, borrow chain: load 0x1000, enable 1 cycle -> Q is 0x0999. Load 0x0100, enable 1 cycle -> Q is 0x0099. No done in either case.
REQ-030 Scenario, illegal load: with Q=0x0042, load 0x00A5 -> Q remains 0x0042; load_err is 1 for one cycle; done stays 0.
REQ-031 Scenario, simultaneous load and enable: with Q=0x0010, drive load=1, load_val=0x0500, enable=1 -> Q is 0x0500 (not 0x04FF or 0x0499). Then drive reset=1 with load=1 -> Q is 0x0000.
REQ-032 Scenario, enable at zero: with Q=0x0000, enable 2 cycles. Without the macro, Q stays 0x0000 and done stays 0. With the macro, after an earlier load of 0x0002, Q becomes 0x0002 then 0x0001, with no done.
REQ-033 Scenario, exhaustive decrement: NUM_DIGITS=2, load 0x99, enable 99 cycles -> Q follows 98, 97 ... 00 in decimal with no non-BCD digit; done pulses once, at the step 01 -> 00.

Source files
------------

// File: rtl/bcd_down_counter.sv
// bcd_down_counter: loadable multi-digit BCD down counter.
// Q counts down in decimal on enable, stops at zero, and pulses done when a
// decrement lands on zero. Loads containing a non-BCD digit are rejected and
// flagged with a one-cycle load_err pulse.
// Optional feature: define BCD_DOWN_COUNTER_AUTO_RELOAD_EN to keep a reload
// register holding the last accepted load value; an enable at zero then
// restarts the count from that value instead of holding at zero.
module bcd_down_counter #(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  input  logic                    enable,
  output logic [4*NUM_DIGITS-1:0] Q,
  output logic                    zero,
  output logic                    done,
  output logic                    load_err
);

  localparam int W = 4 * NUM_DIGITS;

  logic [W-1:0] count_q, count_d;
  logic         done_q, done_d;
  logic         loadErr_q, loadErr_d;
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
  logic [W-1:0] reload_q, reload_d;
`endif

  logic         loadOk;
  logic [W-1:0] decVal;
  logic         borrow;
  logic         isZero;

  assign isZero = (count_q == '0);

  // Validate every load digit and form the decimal decrement of Q, with the
  // borrow rippling from digit 0 upward; a digit at 0 wraps to 9 and keeps
  // borrowing, the first nonzero digit absorbs the borrow.
  always_comb begin
    loadOk = 1'b1;
    decVal = count_q;
    borrow = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) begin
        loadOk = 1'b0;
      end
      if (borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          decVal[4*i +: 4] = 4'd9;
        end else begin
          decVal[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          borrow           = 1'b0;
        end
      end
    end
  end

  // Next-state selection: load beats enable, enable beats hold; the pulses
  // default low so they last exactly one cycle.
  always_comb begin
    count_d   = count_q;
    done_d    = 1'b0;
    loadErr_d = 1'b0;
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
    reload_d  = reload_q;
`endif
    if (load) begin
      if (loadOk) begin
        count_d  = load_val;
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
        reload_d = load_val;
`endif
      end else begin
        loadErr_d = 1'b1;
      end
    end else if (enable) begin
      if (!isZero) begin
        count_d = decVal;
        done_d  = (decVal == '0);
      end else begin
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
        count_d = reload_q;
`else
        count_d = count_q;
`endif
      end
    end
  end

  // State registers with synchronous reset that overrides load and enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      done_q    <= 1'b0;
      loadErr_q <= 1'b0;
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
      reload_q  <= '0;
`endif
    end else begin
      count_q   <= count_d;
      done_q    <= done_d;
      loadErr_q <= loadErr_d;
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
      reload_q  <= reload_d;
`endif
    end
  end

  assign Q        = count_q;
  assign zero     = isZero;
  assign done     = done_q;
  assign load_err = loadErr_q;

endmodule

// File: tb/tb_bcd_down_counter.sv
// tb_bcd_down_counter: scoreboard bench for bcd_down_counter (NUM_DIGITS=4).
// The driver applies directed scenarios followed by random traffic, runs an
// integer-valued reference model and queues the expected outputs; a monitor
// pops one expectation per clock edge and compares.
module tb_bcd_down_counter;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         enable = 1'b0;
  logic [W-1:0] Q;
  logic         zero;
  logic         done;
  logic         load_err;

  typedef struct {
    logic [W-1:0] q;
    logic         done;
    logic         err;
  } expT;

  expT sb[$];

  int total = 0;
  int bad   = 0;

  int modelVal  = 0;
  int reloadVal = 0;

  bcd_down_counter #(.NUM_DIGITS(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .enable   (enable),
    .Q        (Q),
    .zero     (zero),
    .done     (done),
    .load_err (load_err)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  function automatic bit isLegal(input logic [W-1:0] b);
    logic [W-1:0] t;
    t = b;
    for (int i = 0; i < N; i++) begin
      if (t[3:0] > 4'd9) return 1'b0;
      t = t >> 4;
    end
    return 1'b1;
  endfunction

  function automatic int bcdToInt(input logic [W-1:0] b);
    int r;
    logic [W-1:0] t;
    r = 0;
    t = b;
    for (int i = 0; i < N; i++) begin
      r = r * 10 + int'(t[W-1 -: 4]);
      t = t << 4;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] intToBcd(input int v);
    logic [W-1:0] b;
    int x;
    b = '0;
    x = v;
    for (int i = 0; i < N; i++) begin
      b = b | (W'(x % 10) << (4 * i));
      x = x / 10;
    end
    return b;
  endfunction

  function automatic logic [W-1:0] randomVal(input bit allowIllegal);
    logic [W-1:0] b;
    int sel;
    b = '0;
    sel = $urandom_range(0, 3);
    for (int i = 0; i < N; i++) begin
      if (sel == 0 && i > 0) begin
        b = b;
      end else if (allowIllegal) begin
        b = b | (W'($urandom_range(0, 15)) << (4 * i));
      end else begin
        b = b | (W'($urandom_range(0, 9)) << (4 * i));
      end
    end
    return b;
  endfunction

  // Drive one cycle of inputs, advance the reference model and queue the
  // outputs expected after the coming rising edge.
  task automatic applyStimulus(input logic r, input logic l,
                               input logic [W-1:0] v, input logic e);
    expT x;
    @(negedge clk);
    reset    = r;
    load     = l;
    load_val = v;
    enable   = e;
    x.done = 1'b0;
    x.err  = 1'b0;
    if (r) begin
      modelVal  = 0;
      reloadVal = 0;
    end else if (l) begin
      if (isLegal(v)) begin
        modelVal  = bcdToInt(v);
        reloadVal = modelVal;
      end else begin
        x.err = 1'b1;
      end
    end else if (e) begin
      if (modelVal != 0) begin
        modelVal = modelVal - 1;
        x.done   = (modelVal == 0);
      end else begin
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
        modelVal = reloadVal;
`endif
      end
    end
    x.q = intToBcd(modelVal);
    sb.push_back(x);
  endtask

  task automatic checkOutput(input expT x);
    total++;
    if (Q !== x.q) begin
      bad++;
      $display("[TB] FAIL Q: got %h expected %h at %0t", Q, x.q, $time);
    end
    total++;
    if (zero !== (x.q == '0)) begin
      bad++;
      $display("[TB] FAIL zero: got %b expected %b at %0t", zero, (x.q == '0), $time);
    end
    total++;
    if (done !== x.done) begin
      bad++;
      $display("[TB] FAIL done: got %b expected %b at %0t", done, x.done, $time);
    end
    total++;
    if (load_err !== x.err) begin
      bad++;
      $display("[TB] FAIL load_err: got %b expected %b at %0t", load_err, x.err, $time);
    end
  endtask

  // Monitor: one expectation is consumed per rising edge, sampled 1 ns later.
  always @(posedge clk) begin
    expT x;
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      checkOutput(x);
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] v;
    // Reset, including reset overriding load and enable.
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h1234, 1'b1);
    // Load 3 and count down to zero, then idle.
    applyStimulus(1'b0, 1'b1, 16'h0003, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    repeat (2) applyStimulus(1'b0, 1'b0, '0, 1'b0);
    // Borrow chains.
    applyStimulus(1'b0, 1'b1, 16'h1000, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h0100, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    // Illegal load is rejected, enable alongside it ignored.
    applyStimulus(1'b0, 1'b1, 16'h0042, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h00A5, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    // Load wins over enable; reset wins over load.
    applyStimulus(1'b0, 1'b1, 16'h0010, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0500, 1'b1);
    applyStimulus(1'b1, 1'b1, 16'h0500, 1'b0);
    // Enable at zero: count a load of 2 down, then keep enabling.
    applyStimulus(1'b0, 1'b1, 16'h0002, 1'b0);
    repeat (6) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    // Load of zero must not pulse done.
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    // Full decrement sweep from 99 down to 00.
    applyStimulus(1'b0, 1'b1, 16'h0099, 1'b0);
    repeat (99) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    // Top of range.
    applyStimulus(1'b0, 1'b1, 16'h9999, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      v = randomVal($urandom_range(0, 3) == 0);
      applyStimulus($urandom_range(0, 99) < 3,
                    $urandom_range(0, 99) < 15,
                    v,
                    $urandom_range(0, 99) < 75);
    end
    @(negedge clk);
    reset  = 1'b0;
    load   = 1'b0;
    enable = 1'b0;
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    #2;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
